// File: rtl/uart_rx_frame.sv
// Serial frame receiver: hunts for a start bit on quarter-bit ticks, then samples
// data and stop bits on bit-rate ticks and reports good bytes or framing errors.
module uart_rx_frame #(
    parameter int DATA_BITS   = 8,
    parameter int START_QUAL  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_50,
    input  logic                 RESET,
    input  logic                 SAMPLE,
    input  logic                 RX,
    output logic                 CHANGE,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 DATA_VALID,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int QW = $clog2(START_QUAL + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [QW-1:0] QUAL_LAST = QW'(START_QUAL - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } state_t;

    state_t                 state, state_n;
    logic [QW-1:0]          qual_cnt, qual_n;
    logic [BW-1:0]          bit_cnt, bit_n;
    logic [DATA_BITS-1:0]   shift_q, shift_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    logic                   change_n, valid_n, err_n, busy_n;
    logic [DATA_BITS-1:0]   data_n;

    // Synchroniser presets to 1 so a reset looks like an idle line
    always_ff @(posedge clk_50 or negedge RESET) begin
        if (!RESET) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_50 or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            qual_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            CHANGE     <= 1'b0;
            DATA       <= '0;
            DATA_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state      <= state_n;
            qual_cnt   <= qual_n;
            bit_cnt    <= bit_n;
            shift_q    <= shift_n;
            CHANGE     <= change_n;
            DATA       <= data_n;
            DATA_VALID <= valid_n;
            FRAME_ERR  <= err_n;
            BUSY       <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        qual_n  = qual_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_q;
        if (SAMPLE) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        if (START_QUAL == 1) begin
                            state_n = ST_DATA;
                            bit_n   = '0;
                        end else begin
                            state_n = ST_START;
                            qual_n  = QW'(1);
                        end
                    end
                end
                ST_START: begin
                    if (rx_s) begin
                        state_n = ST_IDLE;
                    end else if (qual_cnt == QUAL_LAST) begin
                        state_n = ST_DATA;
                        bit_n   = '0;
                    end else begin
                        qual_n = qual_cnt + QW'(1);
                    end
                end
                ST_DATA: begin
                    // Line is LSB first, so each new bit enters at the top
                    shift_n = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_LAST) state_n = ST_STOP;
                    else                     bit_n   = bit_cnt + BW'(1);
                end
                ST_STOP: state_n = rx_s ? ST_IDLE : ST_BRK;
                ST_BRK:  if (rx_s) state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered copies switch on the tick edge
    always_comb begin
        change_n = (state_n == ST_DATA) || (state_n == ST_STOP);
        busy_n   = (state_n != ST_IDLE);
        valid_n  = SAMPLE && (state == ST_STOP) && rx_s;
        err_n    = SAMPLE && (state == ST_STOP) && !rx_s;
        data_n   = valid_n ? shift_q : DATA;
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame with a behavioural tick generator; the bit period is
// scaled down from 5208 clocks so the whole run stays short.
module tb_uart_rx_frame;

    localparam int BIT_CLKS = 100;
    localparam int QUARTER  = BIT_CLKS / 4;

    logic       clk_50 = 1'b0;
    logic       RESET;
    logic       SAMPLE;
    logic       RX;
    logic       CHANGE;
    logic [7:0] DATA;
    logic       DATA_VALID;
    logic       FRAME_ERR;
    logic       BUSY;

    typedef struct {
        logic       isErr;
        logic [7:0] data;
    } expect_t;

    expect_t    sb[$];
    logic [7:0] lastGood;
    int         checkCount = 0;
    int         passCount  = 0;
    int         tickCnt;
    logic       changeSeen;
    logic       prevValid = 1'b0;
    logic       prevErr   = 1'b0;

    uart_rx_frame dut (
        .clk_50     (clk_50),
        .RESET      (RESET),
        .SAMPLE     (SAMPLE),
        .RX         (RX),
        .CHANGE     (CHANGE),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .FRAME_ERR  (FRAME_ERR),
        .BUSY       (BUSY)
    );

    always #10 clk_50 = ~clk_50;

    // Tick generator: the period follows CHANGE and the counter keeps running across a switch
    always @(posedge clk_50 or negedge RESET) begin
        if (!RESET) begin
            tickCnt <= 0;
            SAMPLE  <= 1'b0;
        end else if (tickCnt >= (CHANGE ? BIT_CLKS : QUARTER) - 1) begin
            tickCnt <= 0;
            SAMPLE  <= 1'b1;
        end else begin
            tickCnt <= tickCnt + 1;
            SAMPLE  <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Every pulse must match the oldest outstanding expectation
    always @(negedge clk_50) begin
        if (RESET) begin
            if (CHANGE) changeSeen = 1'b1;
            if (DATA_VALID && FRAME_ERR) checkOutput("valid_err_overlap", 32'd1, 32'd0);
            if (DATA_VALID && prevValid) checkOutput("valid_width", 32'd2, 32'd1);
            if (FRAME_ERR && prevErr)    checkOutput("err_width", 32'd2, 32'd1);
            if (DATA_VALID || FRAME_ERR) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", {30'd0, DATA_VALID, FRAME_ERR}, 32'd0);
                end else begin
                    expect_t e;
                    e = sb.pop_front();
                    checkOutput("pulse_kind", {31'd0, FRAME_ERR}, {31'd0, e.isErr});
                    checkOutput("data", {24'd0, DATA}, {24'd0, e.data});
                end
            end
        end
        prevValid = DATA_VALID;
        prevErr   = FRAME_ERR;
    end

    task automatic holdLine(input logic v, input int n);
        RX = v;
        repeat (n) @(negedge clk_50);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int bitClks);
        if (stopBit) begin
            sb.push_back('{isErr: 1'b0, data: b});
            lastGood = b;
        end else begin
            sb.push_back('{isErr: 1'b1, data: lastGood});
        end
        holdLine(1'b0, bitClks);
        for (int i = 0; i < 8; i++) holdLine(b[i], bitClks);
        holdLine(stopBit, bitClks);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_change"}, {31'd0, CHANGE}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        checkOutput({tag, "_pending"}, sb.size(), 32'd0);
    endtask

    initial begin
        lastGood = 8'h00;
        RESET    = 1'b0;
        RX       = 1'b1;
        repeat (3) @(negedge clk_50);
        checkOutput("rst_change", {31'd0, CHANGE}, 32'd0);
        checkOutput("rst_data", {24'd0, DATA}, 32'd0);
        checkOutput("rst_valid", {31'd0, DATA_VALID}, 32'd0);
        checkOutput("rst_err", {31'd0, FRAME_ERR}, 32'd0);
        checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
        RESET = 1'b1;
        holdLine(1'b1, 2 * BIT_CLKS);

        // Good frame, CHANGE must be high mid-frame and low again afterwards
        fork
            applyStimulus(8'hA5, 1'b1, BIT_CLKS);
            begin
                repeat (BIT_CLKS * 5 + BIT_CLKS / 2) @(negedge clk_50);
                checkOutput("a5_change_mid", {31'd0, CHANGE}, 32'd1);
                checkOutput("a5_busy_mid", {31'd0, BUSY}, 32'd1);
            end
        join
        holdLine(1'b1, 2 * BIT_CLKS);
        checkIdle("a5");
        checkOutput("a5_data_hold", {24'd0, DATA}, 32'hA5);

        // Quarter-bit glitch is rejected
        changeSeen = 1'b0;
        holdLine(1'b0, QUARTER);
        holdLine(1'b1, 2 * BIT_CLKS);
        checkOutput("glitch_change_seen", {31'd0, changeSeen}, 32'd0);
        checkIdle("glitch");

        // Framing error, break held low, then recovery
        applyStimulus(8'h3C, 1'b0, BIT_CLKS);
        holdLine(1'b0, 3 * BIT_CLKS);
        checkOutput("brk_busy", {31'd0, BUSY}, 32'd1);
        checkOutput("brk_data", {24'd0, DATA}, 32'hA5);
        holdLine(1'b1, 2 * BIT_CLKS);
        checkIdle("brk");
        applyStimulus(8'h11, 1'b1, BIT_CLKS);
        holdLine(1'b1, 2 * BIT_CLKS);
        checkIdle("after_brk");

        // Back-to-back frames with no idle gap
        applyStimulus(8'h00, 1'b1, BIT_CLKS);
        applyStimulus(8'hFF, 1'b1, BIT_CLKS);
        holdLine(1'b1, 2 * BIT_CLKS);
        checkIdle("b2b");
        checkOutput("b2b_data", {24'd0, DATA}, 32'hFF);

        // Reset in the middle of data bit 4 aborts the frame
        holdLine(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) holdLine(1'b1, BIT_CLKS);
        holdLine(1'b0, BIT_CLKS / 2);
        RESET = 1'b0;
        #1;
        checkOutput("midrst_change", {31'd0, CHANGE}, 32'd0);
        checkOutput("midrst_data", {24'd0, DATA}, 32'd0);
        checkOutput("midrst_valid", {31'd0, DATA_VALID}, 32'd0);
        checkOutput("midrst_err", {31'd0, FRAME_ERR}, 32'd0);
        checkOutput("midrst_busy", {31'd0, BUSY}, 32'd0);
        holdLine(1'b1, 5);
        RESET    = 1'b1;
        lastGood = 8'h00;
        holdLine(1'b1, 2 * BIT_CLKS);
        checkIdle("midrst");
        applyStimulus(8'h5A, 1'b1, BIT_CLKS);
        holdLine(1'b1, 2 * BIT_CLKS);
        checkIdle("after_rst");

        // Bit period swept by -2%, 0 and +2%
        for (int k = -1; k <= 1; k++) begin
            applyStimulus(8'h55, 1'b1, BIT_CLKS + k * (BIT_CLKS / 50));
            holdLine(1'b1, 2 * BIT_CLKS);
            checkIdle("sweep");
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
